// File: rtl/sprite_drawer.sv
// Square sprite rasteriser: accepts a top-left corner and streams one framebuffer
// write per cycle in raster order, clipping pixels that fall off-screen.
module sprite_drawer #(
  parameter int SQSIZE = 8,
  parameter int XLIM   = 640,
  parameter int YLIM   = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_x,
  input  logic [10:0] req_y,
  input  logic        req_erase,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        colour,
  output logic        pixel_write,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST = 6'(SQSIZE - 1);

  state_t      state_q, state_d;
  logic [10:0] base_x_q, base_x_d;
  logic [10:0] base_y_q, base_y_d;
  logic        erase_q, erase_d;
  logic [5:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;

  logic [10:0] x_s;
  logic [10:0] y_s;
  logic        in_draw_s;
  logic        on_screen_s;

  // State and captured-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_x_q <= 11'd0;
      base_y_q <= 11'd0;
      erase_q  <= 1'b0;
      col_q    <= 6'd0;
      row_q    <= 6'd0;
    end else begin
      state_q  <= state_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      erase_q  <= erase_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  // Next-state logic and raster counters.
  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    erase_d  = erase_q;
    col_d    = col_q;
    row_d    = row_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = DRAW;
          base_x_d = req_x;
          base_y_d = req_y;
          erase_d  = req_erase;
          col_d    = 6'd0;
          row_d    = 6'd0;
        end else begin
          state_d  = IDLE;
        end
      end
      DRAW: begin
        if (col_q == LAST) begin
          col_d = 6'd0;
          if (row_q == LAST) begin
            row_d   = 6'd0;
            state_d = DONE;
          end else begin
            row_d   = row_q + 6'd1;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; all terms come straight from async-reset flops so reset
  // clears the write strobe without waiting for a clock.
  always_comb begin
    x_s         = base_x_q + {5'd0, col_q};
    y_s         = base_y_q + {5'd0, row_q};
    in_draw_s   = (state_q == DRAW);
    on_screen_s = ({21'd0, x_s} < 32'(XLIM)) && ({21'd0, y_s} < 32'(YLIM));
    x           = x_s;
    y           = y_s;
    colour      = in_draw_s & ~erase_q;
    pixel_write = in_draw_s & on_screen_s;
    done        = (state_q == DONE);
    req_ready   = (state_q == IDLE);
  end

endmodule

// File: tb/tb_sprite_drawer.sv
// Directed bench for sprite_drawer (SQSIZE=4): a scoreboard of timed expected
// pixels and done pulses is filled at each handshake and drained by a monitor.
module tb_sprite_drawer;

  localparam int SQ = 4;
  localparam int XL = 640;
  localparam int YL = 480;

  typedef struct {
    int         c;
    logic [10:0] x;
    logic [10:0] y;
    logic        col;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_x;
  logic [10:0] req_y;
  logic        req_erase;
  logic [10:0] x;
  logic [10:0] y;
  logic        colour;
  logic        pixel_write;
  logic        done;

  int   cyc = 0;
  int   writes = 0;
  int   errors = 0;
  int   checks = 0;
  pix_t pq[$];
  int   dq[$];

  sprite_drawer #(.SQSIZE(SQ), .XLIM(XL), .YLIM(YL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_erase(req_erase),
    .x(x), .y(y), .colour(colour), .pixel_write(pixel_write), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare every write and done pulse against the timed scoreboard.
  always @(negedge clk) begin
    pix_t e;
    if (!rst) begin
      while (pq.size() > 0 && pq[0].c < cyc) begin
        chk("missed_pixel_cycle", 32'(cyc), 32'(pq[0].c));
        void'(pq.pop_front());
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        chk("missed_done_cycle", 32'(cyc), 32'(dq[0]));
        void'(dq.pop_front());
      end
      if (pixel_write) begin
        writes++;
        if (pq.size() == 0) begin
          chk("unexpected_write", 32'(pixel_write), 32'd0);
        end else begin
          e = pq.pop_front();
          chk("pix_cycle", 32'(cyc), 32'(e.c));
          chk("pix_xy_colour", {9'd0, x, y, colour}, {9'd0, e.x, e.y, e.col});
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [10:0] sx, input logic [10:0] sy, input logic se,
                      input bit keep, output int hs);
    int   n;
    pix_t p;
    req_x     = sx;
    req_y     = sy;
    req_erase = se;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", 32'(req_ready), 32'd1);
    hs = cyc + 1;
    for (int r = 0; r < SQ; r++) begin
      for (int c = 0; c < SQ; c++) begin
        if (int'(sx) + c < XL && int'(sy) + r < YL) begin
          p.c   = hs + r * SQ + c;
          p.x   = 11'(int'(sx) + c);
          p.y   = 11'(int'(sy) + r);
          p.col = ~se;
          pq.push_back(p);
        end
      end
    end
    dq.push_back(hs + SQ * SQ);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int hs, hs2, w0, c0;
    rst = 1'b1; req_valid = 1'b0; req_x = 11'd0; req_y = 11'd0; req_erase = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_write", 32'(pixel_write), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_xyc", {9'd0, x, y, colour}, 32'd0);
    rst = 1'b0;

    // Basic draw, then done and ready timing.
    send(11'd10, 11'd20, 1'b0, 1'b0, hs);
    wait_cyc(hs + 16);
    chk("ready_low_in_done", 32'(req_ready), 32'd0);
    wait_cyc(hs + 17);
    chk("ready_after_done", 32'(req_ready), 32'd1);

    // Erase.
    send(11'd10, 11'd20, 1'b1, 1'b0, hs);
    wait_cyc(hs + 17);

    // Clipping at bottom-right corner.
    w0 = writes;
    send(11'd638, 11'd478, 1'b0, 1'b0, hs);
    wait_cyc(hs + 17);
    chk("clip_writes", 32'(writes - w0), 32'd4);

    // Request churn during DRAW is ignored.
    send(11'd200, 11'd100, 1'b0, 1'b0, hs);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = i[0];
      req_x = 11'(300 + i);
      req_y = 11'(7 * i);
      req_erase = i[1];
      chk("ready_in_draw", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    wait_cyc(hs + 17);
    repeat (4) begin
      @(negedge clk);
      chk("idle_stays_idle", {30'd0, req_ready, done}, 32'd2);
    end

    // Reset mid-draw.
    send(11'd40, 11'd40, 1'b1, 1'b0, hs);
    wait_cyc(hs + 5);
    #1;
    chk("write_before_rst", 32'(pixel_write), 32'd1);
    rst = 1'b1;
    pq.delete();
    dq.delete();
    #1;
    chk("rst_async_write", 32'(pixel_write), 32'd0);
    chk("rst_async_ready_done", {30'd0, req_ready, done}, 32'd2);
    chk("rst_async_xyc", {9'd0, x, y, colour}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    c0 = cyc;
    send(11'd5, 11'd7, 1'b0, 1'b0, hs);
    chk("hs_after_rst", 32'(hs), 32'(c0 + 1));
    wait_cyc(hs + 17);

    // Back-to-back with req_valid held high.
    send(11'd1, 11'd2, 1'b0, 1'b1, hs);
    send(11'd20, 11'd30, 1'b1, 1'b0, hs2);
    chk("b2b_gap", 32'(hs2 - hs), 32'(SQ * SQ + 2));
    wait_cyc(hs2 + 18);

    chk("pixels_drained", 32'(pq.size()), 32'd0);
    chk("dones_drained", 32'(dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
